// File: rtl/grain_pkg.sv
// Shared definitions for the grain keystream consumer: state encoding,
// default word width / warm-up length, and the generator seed width.
package grain_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WARMUP_DEF = 160;
  localparam int SEED_W     = 105;

  // State encoding, also visible on the debug state output.
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WARM = 3'd2;
  localparam logic [2:0] RDY  = 3'd3;
  localparam logic [2:0] XOR  = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = IDLE,
    S_LOAD = LOAD,
    S_WARM = WARM,
    S_RDY  = RDY,
    S_XOR  = XOR,
    S_OUT  = OUT
  } state_t;

endpackage

// File: rtl/grain_stream_xor.sv
// Keystream consumer / sequencer for the grain generator.
// Loads the generator, discards WARMUP keystream bits, then XORs each
// DATA_W-bit word with DATA_W fresh keystream bits, LSB first.
// Optional macro GRAIN_KS_TAP_EN adds ks_word (raw keystream of last word).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid never waits on ready, and once out_valid is raised out_data
// is held until out_ready is seen.
module grain_stream_xor
  import grain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              gen_par_load,
  output logic              gen_shift_en,
  input  logic              ks_bit,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef GRAIN_KS_TAP_EN
  output logic [DATA_W-1:0] ks_word,
`endif
  output logic [2:0]        dbg_state
);

  localparam int WCW = $clog2(WARMUP + 1);
  localparam int BCW = $clog2(DATA_W + 1);

  state_t            state;
  logic [WCW-1:0]    warm_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] data_q;

  assign out_data  = data_q;
  assign dbg_state = state;

  // Session FSM; every control output is registered alongside the state.
  // During XOR the word rotates right once per keystream bit, so after
  // DATA_W rotations each bit is back in place, XORed with its own ks bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      gen_par_load <= 1'b0;
      gen_shift_en <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      warm_cnt     <= '0;
      bit_cnt      <= '0;
      data_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LOAD;
            gen_par_load <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_LOAD: begin
          state        <= S_WARM;
          gen_par_load <= 1'b0;
          gen_shift_en <= 1'b1;
          warm_cnt     <= '0;
        end
        S_WARM: begin
          if (warm_cnt == WCW'(WARMUP - 1)) begin
            state        <= S_RDY;
            gen_shift_en <= 1'b0;
            in_ready     <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_RDY: begin
          // stop has priority over an offered word
          if (stop) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid) begin
            state        <= S_XOR;
            data_q       <= in_data;
            in_ready     <= 1'b0;
            gen_shift_en <= 1'b1;
            bit_cnt      <= '0;
          end
        end
        S_XOR: begin
          data_q <= {data_q[0] ^ ks_bit, data_q[DATA_W-1:1]};
          if (bit_cnt == BCW'(DATA_W - 1)) begin
            state        <= S_OUT;
            gen_shift_en <= 1'b0;
            out_valid    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_OUT: begin
          // generator stays frozen until the sink takes the word
          if (out_ready) begin
            state     <= S_RDY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          gen_par_load <= 1'b0;
          gen_shift_en <= 1'b0;
          in_ready     <= 1'b0;
          out_valid    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRAIN_KS_TAP_EN
  logic [DATA_W-1:0] ks_q;

  assign ks_word = ks_q;

  // Keystream bits of the current word, shifted in LSB first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks_q <= '0;
    end else if (state == S_XOR) begin
      ks_q <= {ks_bit, ks_q[DATA_W-1:1]};
    end
  end
`endif

endmodule
